// File: rtl/draw_scheduler_if.sv
// Draw-scheduler bus: frame/slot control in, drawer grants and status out.
interface draw_scheduler_if;
    localparam int unsigned NSLOT = 3;

    logic             frame_tick;
    logic [NSLOT-1:0] slot_en;
    logic [NSLOT-1:0] done;
    logic [NSLOT-1:0] go;
    logic [1:0]       draw_mux;
    logic             iscolour;
    logic             inc_enable;
    logic             busy;
    logic             overrun;
    logic             timeout_err;

    modport master (
        output frame_tick, slot_en, done,
        input  go, draw_mux, iscolour, inc_enable, busy, overrun, timeout_err
    );

    modport slave (
        input  frame_tick, slot_en, done,
        output go, draw_mux, iscolour, inc_enable, busy, overrun, timeout_err
    );
endinterface

// File: rtl/draw_scheduler.sv
// Sequences erase pass, one game-logic step and colour pass over the shared VGA draw path.
// Optional macro ARB_TIMEOUT_EN: force-advance a drawer whose done never arrives.
module draw_scheduler #(
    parameter int unsigned LOGIC_WAIT = 12,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned CW         = 10
) (
    input  logic            clk,
    input  logic            resetn,
    draw_scheduler_if.slave bus
);
    localparam int unsigned   NSLOT       = 3;
    localparam int unsigned   SW          = 2;
    localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
    localparam logic [CW-1:0] SETTLE_LAST = CW'(LOGIC_WAIT - 1);

    if (LOGIC_WAIT == 0 || LOGIC_WAIT > (32'd1 << CW)) begin : g_bad_logic_wait
        $error("draw_scheduler: LOGIC_WAIT must lie in 1..2**CW");
    end
    if (TIMEOUT == 0 || TIMEOUT > (32'd1 << CW)) begin : g_bad_timeout
        $error("draw_scheduler: TIMEOUT must lie in 1..2**CW");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_GO,
        S_WAIT,
        S_LOGIC,
        S_SETTLE
    } state_e;

    state_e           state_q;
    logic [SW-1:0]    slot_q;
    logic [CW-1:0]    cnt_q;
    logic [NSLOT-1:0] go_q;
    logic [1:0]       mux_q;
    logic             iscolour_q;
    logic             inc_q;
    logic             busy_q;
    logic             overrun_q;

    logic             pick_found_d;
    logic [SW-1:0]    pick_idx_d;
    logic [CW-1:0]    cnt_d;

    // Drawer slot to existing mux encoding (bricks sit at select 0).
    function automatic logic [1:0] mux_sel(input logic [SW-1:0] s);
        case (s)
            2'd0:    mux_sel = 2'd1;
            2'd1:    mux_sel = 2'd0;
            2'd2:    mux_sel = 2'd2;
            default: mux_sel = 2'd0;
        endcase
    endfunction

    // First enabled slot at or above the current slot; slot 3 means pass finished.
    always_comb begin
        pick_found_d = 1'b0;
        pick_idx_d   = '0;
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (!pick_found_d && (32'(slot_q) <= i) && bus.slot_en[i]) begin
                pick_found_d = 1'b1;
                pick_idx_d   = SW'(i);
            end
        end
    end

    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

`ifdef ARB_TIMEOUT_EN
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    logic timeout_err_q;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            cnt_q      <= '0;
            go_q       <= '0;
            mux_q      <= '0;
            iscolour_q <= 1'b0;
            inc_q      <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
        end else begin
            go_q  <= '0;
            inc_q <= 1'b0;
            if (bus.frame_tick && (state_q != S_IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.frame_tick) begin
                        state_q    <= S_PICK;
                        slot_q     <= '0;
                        iscolour_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_PICK: begin
                    if (pick_found_d) begin
                        state_q <= S_GO;
                        slot_q  <= pick_idx_d;
                        go_q    <= NSLOT'(1) << pick_idx_d;
                        mux_q   <= mux_sel(pick_idx_d);
                    end else if (!iscolour_q) begin
                        state_q <= S_LOGIC;
                        inc_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                S_GO: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    if (bus.done[slot_q]) begin
                        state_q <= S_PICK;
                        slot_q  <= slot_q + SW'(1);
`ifdef ARB_TIMEOUT_EN
                    end else if (cnt_q >= TIMEOUT_LAST) begin
                        state_q       <= S_PICK;
                        slot_q        <= slot_q + SW'(1);
                        timeout_err_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_LOGIC: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= '0;
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_q    <= S_PICK;
                        slot_q     <= '0;
                        iscolour_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.go         = go_q;
    assign bus.draw_mux   = mux_q;
    assign bus.iscolour   = iscolour_q;
    assign bus.inc_enable = inc_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = overrun_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: frame-timeline model checked every cycle plus hand-computed event checks.
module tb_draw_scheduler;
    localparam int unsigned LW   = 12;
`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TO   = 20;
`else
    localparam int unsigned TO   = 1023;
`endif
    localparam int          NCYC = 2048;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    draw_scheduler_if bus ();

    draw_scheduler #(.LOGIC_WAIT(LW), .TIMEOUT(TO), .CW(10)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Expected per-cycle outputs derived from the frame timeline.
    logic [2:0] e_go   [NCYC];
    logic [1:0] e_mux  [NCYC];
    bit         e_inc  [NCYC];
    bit         e_busy [NCYC];
    bit         e_grant[NCYC];
    bit         e_col  [NCYC];
    bit         e_ovr  [NCYC];
    bit         e_tmo  [NCYC];

    int mux_of [3] = '{1, 0, 2};
    int lat    [3] = '{3, 3, 3};
    int due    [3] = '{-1, -1, -1};
    logic [2:0] force_done = 3'b000;
    int         force_cyc  = -1;

    int go_cyc[$];
    int go_val[$];
    int go_mux[$];
    int go_col[$];
    int inc_cyc[$];

    int rel_t1 [6] = '{2, 7, 12, 31, 36, 41};
    int val_t1 [6] = '{1, 2, 4, 1, 2, 4};

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic void model_clear(input int from);
        for (int k = from; k < NCYC; k++) begin
            e_go[k] = '0; e_mux[k] = '0; e_inc[k] = 1'b0; e_busy[k] = 1'b0;
            e_grant[k] = 1'b0; e_col[k] = 1'b0; e_ovr[k] = 1'b0; e_tmo[k] = 1'b0;
        end
    endfunction

    // Accepted tick at cycle t: erase pass, logic step, settle, colour pass.
    function automatic void plan_frame(input int t, input logic [2:0] en);
        int c, g, d;
        bit hung;
        c = t + 1;
        hung = 1'b0;
        for (int pass = 0; pass < 2 && !hung; pass++) begin
            for (int s = 0; s < 3 && !hung; s++) begin
                if (en[s]) begin
                    g = c + 1;
                    e_go[g] = 3'(1 << s);
                    if (lat[s] == 0) begin
`ifdef ARB_TIMEOUT_EN
                        d = int'(TO);
                        for (int k = g + d + 1; k < NCYC; k++) e_tmo[k] = 1'b1;
`else
                        d = NCYC;
                        hung = 1'b1;
`endif
                    end else begin
                        d = lat[s];
                    end
                    for (int k = g; k <= g + d && k < NCYC; k++) begin
                        e_grant[k] = 1'b1;
                        e_mux[k]   = 2'(mux_of[s]);
                        e_col[k]   = (pass == 1);
                    end
                    c = g + d + 1;
                end
            end
            if (pass == 0 && !hung) begin
                e_inc[c + 1] = 1'b1;
                c = c + 2 + int'(LW);
            end
        end
        for (int k = t + 1; k <= c && k < NCYC; k++) e_busy[k] = 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++) bus.done[i] = (due[i] == cyc);
        if (force_cyc == cyc) bus.done = bus.done | force_done;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic tick();
        if (e_busy[cyc]) begin
            for (int k = cyc + 1; k < NCYC; k++) e_ovr[k] = 1'b1;
        end else begin
            plan_frame(cyc, bus.slot_en);
        end
        bus.frame_tick = 1'b1;
        step();
        bus.frame_tick = 1'b0;
    endtask

    task automatic clear_ev();
        go_cyc.delete(); go_val.delete(); go_mux.delete(); go_col.delete(); inc_cyc.delete();
    endtask

    task automatic pulse_reset();
        resetn = 1'b0;
        model_clear(cyc + 1);
        step();
        resetn = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_go"}, int'(bus.go), 0);
        check({tag, "_mux"}, int'(bus.draw_mux), 0);
        check({tag, "_col"}, int'(bus.iscolour), 0);
        check({tag, "_inc"}, int'(bus.inc_enable), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
        check({tag, "_ovr"}, int'(bus.overrun), 0);
        check({tag, "_tmo"}, int'(bus.timeout_err), 0);
    endtask

    // Responder: drawer i pulses done lat[i] cycles after its go (0 = never).
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (bus.go[i] === 1'b1 && lat[i] != 0) due[i] = cyc + lat[i];
        end
    end

    // Per-cycle compare against the model and event logging.
    always @(negedge clk) begin
        if (chk_en && cyc < NCYC) begin
            check("go", int'(bus.go), int'(e_go[cyc]));
            check("inc_enable", int'(bus.inc_enable), int'(e_inc[cyc]));
            check("busy", int'(bus.busy), int'(e_busy[cyc]));
            check("overrun", int'(bus.overrun), int'(e_ovr[cyc]));
            check("timeout_err", int'(bus.timeout_err), int'(e_tmo[cyc]));
            if (e_grant[cyc]) begin
                check("draw_mux", int'(bus.draw_mux), int'(e_mux[cyc]));
                check("iscolour", int'(bus.iscolour), int'(e_col[cyc]));
            end
        end
        if (bus.go !== 3'b000) begin
            go_cyc.push_back(cyc);
            go_val.push_back(int'(bus.go));
            go_mux.push_back(int'(bus.draw_mux));
            go_col.push_back(int'(bus.iscolour));
        end
        if (bus.inc_enable === 1'b1) inc_cyc.push_back(cyc);
    end

    initial begin
        int t0;
        resetn         = 1'b0;
        bus.frame_tick = 1'b0;
        bus.slot_en    = 3'b000;
        bus.done       = 3'b000;
        model_clear(0);
        run(2);
        check_idle_outputs("reset");
        resetn = 1'b1;
        chk_en = 1'b1;
        run(2);

        // All slots, done 3 cycles after each go.
        lat = '{3, 3, 3};
        bus.slot_en = 3'b111;
        clear_ev();
        t0 = cyc;
        tick();
        run(55);
        check("t1_go_count", go_cyc.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check("t1_go_rel", qget(go_cyc, i) - t0, rel_t1[i]);
            check("t1_go_val", qget(go_val, i), val_t1[i]);
            check("t1_go_col", qget(go_col, i), (i >= 3) ? 1 : 0);
            check("t1_go_mux", qget(go_mux, i), mux_of[i % 3]);
        end
        check("t1_inc_count", inc_cyc.size(), 1);
        check("t1_inc_rel", qget(inc_cyc, 0) - t0, 17);
        check("t1_busy_end", int'(bus.busy), 0);
        check("t1_overrun", int'(bus.overrun), 0);

        // Bricks disabled.
        lat = '{2, 2, 2};
        bus.slot_en = 3'b101;
        clear_ev();
        t0 = cyc;
        tick();
        run(40);
        check("t2_go_count", go_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_no_bricks_go", qget(go_val, i) & 2, 0);
            check("t2_mux_not_bricks", int'(qget(go_mux, i) == 0), 0);
        end
        check("t2_inc_count", inc_cyc.size(), 1);
        check("t2_inc_rel", qget(inc_cyc, 0) - t0, 10);

        // Ball only; spurious bricks done while ball is granted.
        lat = '{6, 2, 2};
        bus.slot_en = 3'b001;
        clear_ev();
        t0 = cyc;
        force_done = 3'b010;
        force_cyc  = t0 + 4;
        tick();
        run(40);
        force_cyc = -1;
        check("t4_go_count", go_cyc.size(), 2);
        check("t4_inc_rel", qget(inc_cyc, 0) - t0, 10);
        check("t4_colour_go_rel", qget(go_cyc, 1) - t0, 24);

        // Second tick mid-frame is dropped and flagged.
        lat = '{3, 3, 3};
        bus.slot_en = 3'b111;
        clear_ev();
        t0 = cyc;
        tick();
        run(4);
        tick();
        run(55);
        check("t3_overrun", int'(bus.overrun), 1);
        check("t3_go_count", go_cyc.size(), 6);
        check("t3_last_go_rel", qget(go_cyc, 5) - t0, 41);
        check("t3_busy_end", int'(bus.busy), 0);

        // Reset during colour-pass WAIT, then a fresh frame.
        clear_ev();
        t0 = cyc;
        tick();
        run(32);
        pulse_reset();
        check_idle_outputs("t5_after_reset");
        run(3);
        clear_ev();
        t0 = cyc;
        tick();
        run(10);
        check("t5_restart_go_rel", qget(go_cyc, 0) - t0, 2);
        check("t5_restart_go_col", qget(go_col, 0), 0);
        run(45);
        check("t5_busy_end", int'(bus.busy), 0);

        // Bricks never answers.
        lat = '{0, 0, 2};
        bus.slot_en = 3'b110;
        clear_ev();
        t0 = cyc;
        tick();
`ifdef ARB_TIMEOUT_EN
        run(80);
        check("t6_wait_cycles", qget(go_cyc, 1) - qget(go_cyc, 0) - 2, int'(TO));
        check("t6_platform_val", qget(go_val, 1), 4);
        check("t6_timeout_err", int'(bus.timeout_err), 1);
        check("t6_busy_end", int'(bus.busy), 0);
`else
        run(200);
        check("t6_stall_busy", int'(bus.busy), 1);
        check("t6_stall_go_count", go_cyc.size(), 1);
        check("t6_stall_mux", int'(bus.draw_mux), 0);
        check("t6_timeout_err", int'(bus.timeout_err), 0);
`endif
        pulse_reset();
        check_idle_outputs("t6_after_reset");
        run(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
